// File: rtl/fb_stream_pkg.sv
// fb_stream_pkg: shared fetch-state type and geometry helpers for the framebuffer streamer
package fb_stream_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;

  function automatic int pixels_per_word(input int ram_width, input int pixel_bits);
    return ram_width / pixel_bits;
  endfunction

  function automatic int words_per_frame(input int h_res, input int v_res, input int ppw);
    return h_res * v_res / ppw;
  endfunction

  function automatic bit packing_ok(input int ram_width, input int pixel_bits);
    return pixel_bits > 0 && ram_width % pixel_bits == 0;
  endfunction

  function automatic bit depth_ok(input int depth);
    return depth >= 2 && (depth & (depth - 1)) == 0;
  endfunction

  function automatic bit latency_ok(input int latency);
    return latency >= 1 && latency <= 4;
  endfunction

endpackage

// File: rtl/fb_word_fifo.sv
// fb_word_fifo: prefetch word FIFO with flush; pop-before-push when full, no empty bypass
module fb_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [PW:0]      count_q, count_d;
  logic             do_pop, do_push;

  // pointer and occupancy update; a pop frees the slot a same-cycle push may take
  always_comb begin
    do_pop  = !flush && pop && count_q != '0;
    do_push = !flush && push && (count_q != FULL_CNT || do_pop);
    rd_d    = flush ? '0 : rd_q + PW'(do_pop);
    wr_d    = flush ? '0 : wr_q + PW'(do_push);
    count_d = flush ? '0 : count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  // pointer and count registers
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end

  // storage array, written only on an accepted push
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_q] <= din;

  assign dout  = mem_q[rd_q];
  assign count = count_q;
  assign empty = count_q == '0;

endmodule

// File: rtl/fb_stream_reader.sv
// fb_stream_reader: prefetches frame RAM words and unpacks them LSB-first into pixels
module fb_stream_reader
  import fb_stream_pkg::*;
#(
  parameter int RAM_WIDTH   = 32,
  parameter int PIXEL_BITS  = 8,
  parameter int H_RES       = 480,
  parameter int V_RES       = 360,
  parameter int RAM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4,
  localparam int PPW        = pixels_per_word(RAM_WIDTH, PIXEL_BITS),
  localparam int WORDS      = words_per_frame(H_RES, V_RES, PPW),
  localparam int ADDR_BITS  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  logic                  pixel_en,
  input  logic                  visible,
  input  logic [RAM_WIDTH-1:0]  ram_data,
  output logic [ADDR_BITS-1:0]  ram_addr,
  output logic                  ram_rd,
  output logic [PIXEL_BITS-1:0] pixel,
  output logic                  pixel_valid,
  output logic                  underflow
);

  localparam int IDX_BITS = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int CNT_BITS = $clog2(FIFO_DEPTH) + 1;

  if (!packing_ok(RAM_WIDTH, PIXEL_BITS)) begin : g_bad_packing
    $error("PIXEL_BITS must divide RAM_WIDTH");
  end
  if (!depth_ok(FIFO_DEPTH)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if (!latency_ok(RAM_LATENCY)) begin : g_bad_latency
    $error("RAM_LATENCY must be in 1..4");
  end

  fetch_state_t           state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic                   rd_q, rd_d;
  logic [RAM_LATENCY-1:0] vld_q, vld_d;
  logic [RAM_WIDTH-1:0]   cur_word_q, cur_word_d;
  logic                   cur_valid_q, cur_valid_d;
  logic [IDX_BITS-1:0]    idx_q, idx_d;
  logic [PIXEL_BITS-1:0]  pixel_q, pixel_d;
  logic                   pixel_valid_q, pixel_valid_d;
  logic                   underflow_q, underflow_d;
  logic [CNT_BITS-1:0]    fifo_count;
  logic [RAM_WIDTH-1:0]   fifo_dout;
  logic                   fifo_empty, fifo_push, fifo_pop;
  logic [31:0]            occ;
  logic                   consume, last;

  fb_word_fifo #(.WIDTH(RAM_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (fifo_push),
    .din   (ram_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // fetch FSM: issue reads while buffered plus outstanding words leave FIFO room
  always_comb begin
    occ     = 32'(fifo_count) + 32'($countones(vld_q)) + 32'(rd_q);
    state_d = state_q;
    addr_d  = addr_q;
    rd_d    = 1'b0;
    if (frame_start) begin
      state_d = RUN;
      addr_d  = '0;
      rd_d    = 1'b1;
    end else if (state_q == RUN) begin
      if (rd_q && addr_q == ADDR_BITS'(WORDS - 1)) state_d = DONE;
      else begin
        addr_d = addr_q + ADDR_BITS'(rd_q);
        rd_d   = occ < 32'(FIFO_DEPTH);
      end
    end
    vld_d     = frame_start ? '0 : (vld_q << 1) | RAM_LATENCY'(rd_q);
    fifo_push = vld_q[RAM_LATENCY-1] && !frame_start;
  end

  // unpacker: refill the current word when empty, step through pixels on visible strobes
  always_comb begin
    last          = idx_q == IDX_BITS'(PPW - 1);
    consume       = pixel_en && visible && cur_valid_q && !frame_start;
    fifo_pop      = !frame_start && !fifo_empty && (!cur_valid_q || (consume && last));
    cur_word_d    = fifo_pop ? fifo_dout : cur_word_q;
    cur_valid_d   = !frame_start && (fifo_pop || (cur_valid_q && !(consume && last)));
    idx_d         = fifo_pop ? '0 : consume ? (last ? '0 : idx_q + 1'b1) : idx_q;
    pixel_d       = consume ? cur_word_q[idx_q*PIXEL_BITS +: PIXEL_BITS] : '0;
    pixel_valid_d = consume;
    underflow_d   = !frame_start && (underflow_q || (pixel_en && visible && !cur_valid_q));
  end

  // state registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      rd_q          <= 1'b0;
      vld_q         <= '0;
      cur_word_q    <= '0;
      cur_valid_q   <= 1'b0;
      idx_q         <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
      underflow_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      rd_q          <= rd_d;
      vld_q         <= vld_d;
      cur_word_q    <= cur_word_d;
      cur_valid_q   <= cur_valid_d;
      idx_q         <= idx_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
      underflow_q   <= underflow_d;
    end

  assign ram_addr    = addr_q;
  assign ram_rd      = rd_q;
  assign pixel       = pixel_q;
  assign pixel_valid = pixel_valid_q;
  assign underflow   = underflow_q;

endmodule

// File: tb/tb_fb_stream_reader.sv
// tb_fb_stream_reader: scoreboard bench for two streamers (RAM latency 1 and 3) on a 4x2 frame
module tb_fb_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_en = 1'b0;
  logic        visible = 1'b0;
  logic [31:0] ram_data1, ram_data3, d1, d2;
  logic [0:0]  ram_addr1, ram_addr3;
  logic        ram_rd1, ram_rd3;
  logic [7:0]  pixel1, pixel3;
  logic        pv1, pv3, uf1, uf3;
  int          n_chk = 0;
  int          n_pass = 0;
  logic [31:0] q1[$];
  logic [31:0] q3[$];
  logic [31:0] e1, e3;

  always #5 clk = ~clk;

  fb_stream_reader #(.RAM_WIDTH(32), .PIXEL_BITS(8), .H_RES(4), .V_RES(2),
                     .RAM_LATENCY(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_en(pixel_en),
    .visible(visible), .ram_data(ram_data1), .ram_addr(ram_addr1), .ram_rd(ram_rd1),
    .pixel(pixel1), .pixel_valid(pv1), .underflow(uf1));

  fb_stream_reader #(.RAM_WIDTH(32), .PIXEL_BITS(8), .H_RES(4), .V_RES(2),
                     .RAM_LATENCY(3), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pixel_en(pixel_en),
    .visible(visible), .ram_data(ram_data3), .ram_addr(ram_addr3), .ram_rd(ram_rd3),
    .pixel(pixel3), .pixel_valid(pv3), .underflow(uf3));

  function automatic logic [31:0] word(input int n);
    return {8'(n*4+3), 8'(n*4+2), 8'(n*4+1), 8'(n*4)};
  endfunction

  // RAM models; data outside the read window is poisoned so mistimed captures show up
  always @(posedge clk) begin
    ram_data1 <= ram_rd1 ? word(int'(ram_addr1)) : 32'hDEAD_BEEF;
    d1        <= ram_rd3 ? word(int'(ram_addr3)) : 32'hDEAD_BEEF;
    d2        <= d1;
    ram_data3 <= d2;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    q1.delete();
    q3.delete();
    for (int i = 0; i < 8; i++) begin
      q1.push_back(32'(i));
      q3.push_back(32'(i));
    end
    tick();
    frame_start = 1'b0;
  endtask

  // scoreboard: every valid pixel must be the next expected one; idle pixels must be zero
  always @(negedge clk) if (rst) begin
    if (pv1) begin
      e1 = q1.size() != 0 ? q1.pop_front() : 32'hBAD;
      chk("pix1", 32'(pixel1), e1);
    end else chk("idle_pix1", 32'(pixel1), 0);
    if (pv3) begin
      e3 = q3.size() != 0 ? q3.pop_front() : 32'hBAD;
      chk("pix3", 32'(pixel3), e3);
    end else chk("idle_pix3", 32'(pixel3), 0);
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tick(3);
    chk("rst_addr1", 32'(ram_addr1), 0);
    chk("rst_rd1", 32'(ram_rd1), 0);
    chk("rst_pix1", 32'(pixel1), 0);
    chk("rst_pv1", 32'(pv1), 0);
    chk("rst_uf1", 32'(uf1), 0);
    chk("rst_rd3", 32'(ram_rd3), 0);
    rst = 1'b1;
    tick(3);
    chk("idle_rd1", 32'(ram_rd1), 0);
    chk("idle_rd3", 32'(ram_rd3), 0);
    start_frame();
    chk("rd_a0", 32'(ram_rd1), 1);
    chk("addr_a0", 32'(ram_addr1), 0);
    tick();
    chk("rd_a1", 32'(ram_rd1), 1);
    chk("addr_a1", 32'(ram_addr1), 1);
    tick();
    chk("done_rd", 32'(ram_rd1), 0);
    chk("done_addr", 32'(ram_addr1), 1);
    tick(3);
    chk("done_rd_hold", 32'(ram_rd1), 0);
    chk("done_addr_hold", 32'(ram_addr1), 1);
    tick(4);
    visible = 1'b1;
    for (int i = 0; i < 8; i++) begin
      pixel_en = 1'b1;
      tick();
      pixel_en = 1'b0;
      chk("strobe_pv", 32'(pv1), 1);
      chk("strobe_pix", 32'(pixel1), 32'(i));
      tick(3);
    end
    chk("uf_none1", 32'(uf1), 0);
    chk("uf_none3", 32'(uf3), 0);
    chk("sb_empty1", 32'(q1.size()), 0);
    chk("sb_empty3", 32'(q3.size()), 0);
    pixel_en = 1'b1;
    tick();
    pixel_en = 1'b0;
    chk("ninth_pv", 32'(pv1), 0);
    chk("ninth_pix", 32'(pixel1), 0);
    chk("ninth_uf", 32'(uf1), 1);
    tick(5);
    chk("uf_sticky1", 32'(uf1), 1);
    chk("uf_sticky3", 32'(uf3), 1);
    pixel_en = 1'b1;
    start_frame();
    chk("uf_clr1", 32'(uf1), 0);
    chk("uf_clr3", 32'(uf3), 0);
    tick(2);
    chk("uf_early1", 32'(uf1), 1);
    chk("uf_early3", 32'(uf3), 1);
    tick(20);
    pixel_en = 1'b0;
    tick(2);
    chk("burst_empty1", 32'(q1.size()), 0);
    chk("burst_empty3", 32'(q3.size()), 0);
    visible = 1'b0;
    tick(2);
    start_frame();
    tick(10);
    visible = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pixel_en = 1'b1;
      tick();
      pixel_en = 1'b0;
      tick(3);
    end
    chk("partial_left1", 32'(q1.size()), 5);
    start_frame();
    tick();
    chk("inflight_rd1", 32'(ram_rd1), 1);
    start_frame();
    tick(10);
    for (int i = 0; i < 8; i++) begin
      pixel_en = 1'b1;
      tick();
      pixel_en = 1'b0;
      tick(3);
    end
    chk("restart_empty1", 32'(q1.size()), 0);
    chk("restart_empty3", 32'(q3.size()), 0);
    chk("restart_uf1", 32'(uf1), 0);
    chk("restart_uf3", 32'(uf3), 0);
    pixel_en = 1'b1;
    start_frame();
    tick();
    chk("pre_rst_rd1", 32'(ram_rd1), 1);
    chk("pre_rst_uf1", 32'(uf1), 1);
    #1 rst = 1'b0;
    #1;
    chk("arst_addr1", 32'(ram_addr1), 0);
    chk("arst_rd1", 32'(ram_rd1), 0);
    chk("arst_pix1", 32'(pixel1), 0);
    chk("arst_pv1", 32'(pv1), 0);
    chk("arst_uf1", 32'(uf1), 0);
    chk("arst_rd3", 32'(ram_rd3), 0);
    chk("arst_uf3", 32'(uf3), 0);
    pixel_en = 1'b0;
    q1.delete();
    q3.delete();
    #1 rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_rd1", 32'(ram_rd1), 0);
      chk("post_rst_rd3", 32'(ram_rd3), 0);
    end
    visible = 1'b0;
    start_frame();
    chk("restart_rd1", 32'(ram_rd1), 1);
    chk("restart_addr1", 32'(ram_addr1), 0);
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
